// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped, write-back data cache.
package dcache_pkg;
  typedef enum logic [1:0] {IDLE, WRITE_BACK, MEM_READ, UPDATE} state_t;

  localparam int ADDR_W      = 8;
  localparam int BLOCK_BYTES = 4;
  localparam int OFFSET_W    = $clog2(BLOCK_BYTES);
  localparam int LINE_W      = BLOCK_BYTES * 8;
  localparam int MEM_ADDR_W  = ADDR_W - OFFSET_W;
endpackage

// File: rtl/dcache_array.sv
// Line storage: valid/dirty flags (cleared by reset), tags and block data.
module dcache_array import dcache_pkg::*; #(
  parameter int NUM_BLOCKS = 8,
  parameter int IDX_W      = 3,
  parameter int TAG_W      = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_W-1:0]    idx,
  output logic                rd_valid,
  output logic                rd_dirty,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [LINE_W-1:0]   rd_data,
  input  logic                wr_en,
  input  logic [OFFSET_W-1:0] wr_offset,
  input  logic [7:0]          wr_byte,
  input  logic                fill_en,
  input  logic [IDX_W-1:0]    fill_idx,
  input  logic [TAG_W-1:0]    fill_tag,
  input  logic [LINE_W-1:0]   fill_data
);
  logic [NUM_BLOCKS-1:0] valid;
  logic [NUM_BLOCKS-1:0] dirty;
  logic [TAG_W-1:0]      tag_mem  [NUM_BLOCKS];
  logic [LINE_W-1:0]     data_mem [NUM_BLOCKS];

  assign rd_valid = valid[idx];
  assign rd_dirty = dirty[idx];
  assign rd_tag   = tag_mem[idx];
  assign rd_data  = data_mem[idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill_en) begin
      valid[fill_idx] <= 1'b1;
      dirty[fill_idx] <= 1'b0;
    end else if (wr_en) begin
      dirty[idx] <= 1'b1;
    end
  end

  // Tag/data contents survive reset; only the flags decide whether they are used.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= fill_data;
    end else if (wr_en) begin
      data_mem[idx][{wr_offset, 3'b000} +: 8] <= wr_byte;
    end
  end
endmodule

// File: rtl/dcache.sv
// Direct-mapped write-back/write-allocate data cache: hit logic and miss FSM.
module dcache #(
  parameter int NUM_BLOCKS = 8,
  parameter int MEM_ADDR_W = 6
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [7:0]            ADDRESS,
  input  logic [7:0]            WRITEDATA,
  output logic [7:0]            READDATA,
  output logic                  BUSYWAIT,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [MEM_ADDR_W-1:0] mem_address,
  output logic [31:0]           mem_writedata,
  input  logic [31:0]           mem_readdata,
  input  logic                  mem_busywait
);
  import dcache_pkg::*;

  localparam int IDX_W = $clog2(NUM_BLOCKS);
  localparam int TAG_W = ADDR_W - OFFSET_W - IDX_W;

  state_t              state;
  logic [OFFSET_W-1:0] offset;
  logic [IDX_W-1:0]    idx;
  logic [TAG_W-1:0]    tag;
  logic                line_valid;
  logic                line_dirty;
  logic [TAG_W-1:0]    line_tag;
  logic [LINE_W-1:0]   line_data;
  logic                hit;
  logic                req;
  logic                miss;
  logic                wr_hit;
  logic [TAG_W-1:0]    miss_tag;
  logic [IDX_W-1:0]    miss_idx;
  logic [LINE_W-1:0]   fill_data;

  assign offset = ADDRESS[OFFSET_W-1:0];
  assign idx    = ADDRESS[OFFSET_W +: IDX_W];
  assign tag    = ADDRESS[ADDR_W-1 -: TAG_W];

  // Gating with RESET keeps every CPU-facing output quiet while reset is held.
  assign hit    = RESET && line_valid && (line_tag == tag);
  assign req    = READ || WRITE;
  assign miss   = req && !hit;
  assign wr_hit = (state == IDLE) && WRITE && hit;

  assign BUSYWAIT = RESET && ((state != IDLE) || miss);
  assign READDATA = ((state == IDLE) && READ && !WRITE && hit)
                    ? line_data[{offset, 3'b000} +: 8] : 8'h00;

  dcache_array #(
    .NUM_BLOCKS (NUM_BLOCKS),
    .IDX_W      (IDX_W),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk       (CLK),
    .rst_n     (RESET),
    .idx       (idx),
    .rd_valid  (line_valid),
    .rd_dirty  (line_dirty),
    .rd_tag    (line_tag),
    .rd_data   (line_data),
    .wr_en     (wr_hit),
    .wr_offset (offset),
    .wr_byte   (WRITEDATA),
    .fill_en   (state == UPDATE),
    .fill_idx  (miss_idx),
    .fill_tag  (miss_tag),
    .fill_data (fill_data)
  );

  // The missing block is latched so the fill finishes even if the request drops.
  always_ff @(posedge CLK) begin
    if (state == IDLE && miss) begin
      miss_tag <= tag;
      miss_idx <= idx;
    end
    if (state == MEM_READ && !mem_busywait) begin
      fill_data <= mem_readdata;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state         <= IDLE;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            if (line_valid && line_dirty) begin
              state         <= WRITE_BACK;
              mem_write     <= 1'b1;
              mem_address   <= {line_tag, idx};
              mem_writedata <= line_data;
            end else begin
              state       <= MEM_READ;
              mem_read    <= 1'b1;
              mem_address <= {tag, idx};
            end
          end
        end
        WRITE_BACK: begin
          if (!mem_busywait) begin
            state         <= MEM_READ;
            mem_write     <= 1'b0;
            mem_read      <= 1'b1;
            mem_address   <= {miss_tag, miss_idx};
            mem_writedata <= '0;
          end
        end
        MEM_READ: begin
          if (!mem_busywait) begin
            state       <= UPDATE;
            mem_read    <= 1'b0;
            mem_address <= '0;
          end
        end
        UPDATE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache.sv
// Bench for dcache: directed vector table, multi-cycle corner sequences and a
// randomized run against a byte-level architectural model with a memory responder.
module tb_dcache;
  logic        CLK = 1'b0;
  logic        RESET;
  logic        READ;
  logic        WRITE;
  logic [7:0]  ADDRESS;
  logic [7:0]  WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  int checks = 0;
  int errors = 0;
  int mem_lat = 3;
  int mem_cnt = 0;
  logic [31:0] mem [64];
  bit          written [64];

  dcache dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .READ          (READ),
    .WRITE         (WRITE),
    .ADDRESS       (ADDRESS),
    .WRITEDATA     (WRITEDATA),
    .READDATA      (READDATA),
    .BUSYWAIT      (BUSYWAIT),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] base_word(input logic [5:0] b);
    logic [7:0] x;
    x = {2'b00, b} ^ 8'h09;
    return 32'hDDCCBBAA ^ {4{x}};
  endfunction

  function automatic logic [31:0] mem_view(input logic [5:0] b);
    if (written[b]) return mem[b];
    return base_word(b);
  endfunction

  // Memory responder: busy for mem_lat cycles, then one ready cycle per request.
  always @(negedge CLK) begin
    if (mem_read || mem_write) begin
      mem_cnt++;
      if (mem_cnt > mem_lat) begin
        mem_busywait = 1'b0;
        mem_cnt = 0;
        if (mem_write) begin
          mem[mem_address] = mem_writedata;
          written[mem_address] = 1'b1;
        end else begin
          mem_readdata = mem_view(mem_address);
        end
      end else begin
        mem_busywait = 1'b1;
      end
    end else begin
      mem_cnt = 0;
      mem_busywait = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    RESET = 1'b0; READ = 1'b0; WRITE = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1;
    @(posedge CLK); #1;
  endtask

  // Issues one request at posedge+1 and holds it until BUSYWAIT is low at a sample point.
  task automatic do_op(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d,
                       output int cyc, output logic wb, output logic [5:0] wba,
                       output logic [31:0] wbd, output logic [7:0] rdat,
                       output logic excl, output logic tmo);
    READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = d;
    cyc = 0; wb = 1'b0; wba = '0; wbd = '0; excl = 1'b0; tmo = 1'b0;
    #1;
    while (BUSYWAIT && cyc < 200) begin
      if (mem_read && mem_write) excl = 1'b1;
      if (mem_write && !wb) begin
        wb = 1'b1; wba = mem_address; wbd = mem_writedata;
      end
      @(posedge CLK); #1;
      cyc++;
    end
    tmo = BUSYWAIT;
    rdat = READDATA;
    @(posedge CLK); #1;
    READ = 1'b0; WRITE = 1'b0;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [7:0]  a;
    logic [7:0]  d;
    logic        miss;
    logic        wb;
    logic [5:0]  wba;
    logic [31:0] wbd;
    logic [7:0]  rdata;
  } vec_t;

  initial begin
    vec_t        tbl [9];
    int          cyc, n;
    logic        wb, excl, tmo;
    logic [5:0]  wba;
    logic [31:0] wbd, w;
    logic [7:0]  rdat, exp_rd;
    logic [7:0]  ref_bytes [256];
    bit          rv [8];
    bit          rdirty [8];
    logic [2:0]  rt [8];

    tbl[0] = '{1'b1, 1'b0, 8'h24, 8'h00, 1'b0, 1'b0, 6'h00, 32'h0, 8'hAA};
    tbl[1] = '{1'b0, 1'b1, 8'h26, 8'h5A, 1'b0, 1'b0, 6'h00, 32'h0, 8'h00};
    tbl[2] = '{1'b1, 1'b0, 8'h26, 8'h00, 1'b0, 1'b0, 6'h00, 32'h0, 8'h5A};
    tbl[3] = '{1'b1, 1'b0, 8'h45, 8'h00, 1'b1, 1'b1, 6'h09, 32'hDD5ABBAA, 8'hA3};
    tbl[4] = '{1'b1, 1'b0, 8'h24, 8'h00, 1'b1, 1'b0, 6'h00, 32'h0, 8'hAA};
    tbl[5] = '{1'b1, 1'b0, 8'h26, 8'h00, 1'b0, 1'b0, 6'h00, 32'h0, 8'h5A};
    tbl[6] = '{1'b1, 1'b1, 8'h68, 8'h77, 1'b1, 1'b0, 6'h00, 32'h0, 8'h00};
    tbl[7] = '{1'b1, 1'b0, 8'h68, 8'h00, 1'b0, 1'b0, 6'h00, 32'h0, 8'h77};
    tbl[8] = '{1'b1, 1'b0, 8'h88, 8'h00, 1'b1, 1'b1, 6'h1A, 32'hCEDFA877, 8'h81};

    // Reset state, with a request pending that would otherwise miss.
    RESET = 1'b0; READ = 1'b1; WRITE = 1'b0; ADDRESS = 8'h25; WRITEDATA = 8'h00;
    #3;
    check("rst_busywait", {31'd0, BUSYWAIT}, 0);
    check("rst_readdata", {24'd0, READDATA}, 0);
    check("rst_mem_read", {31'd0, mem_read}, 0);
    check("rst_mem_write", {31'd0, mem_write}, 0);
    check("rst_mem_address", {26'd0, mem_address}, 0);
    check("rst_mem_writedata", mem_writedata, 0);
    READ = 1'b0;
    apply_reset();

    // Cold read miss with three busy memory cycles.
    mem_lat = 3;
    READ = 1'b1; ADDRESS = 8'h25;
    #1;
    check("cold_busy_idle", {31'd0, BUSYWAIT}, 1);
    check("cold_idle_no_memrd", {31'd0, mem_read}, 0);
    @(posedge CLK); #1;
    check("cold_mem_read", {31'd0, mem_read}, 1);
    check("cold_mem_write", {31'd0, mem_write}, 0);
    check("cold_mem_address", {26'd0, mem_address}, 32'h09);
    n = 0;
    while (mem_read && n < 50) begin
      n++;
      @(posedge CLK); #1;
    end
    check("cold_memrd_cycles", n, 4);
    check("cold_update_busy", {31'd0, BUSYWAIT}, 1);
    @(posedge CLK); #1;
    check("cold_done_busy", {31'd0, BUSYWAIT}, 0);
    check("cold_readdata", {24'd0, READDATA}, 32'hBB);
    READ = 1'b0;

    // Directed vector table continuing from the cold fill.
    mem_lat = 1;
    for (int i = 0; i < 9; i++) begin
      do_op(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, cyc, wb, wba, wbd, rdat, excl, tmo);
      check($sformatf("vec%0d_timeout", i), {31'd0, tmo}, 0);
      check($sformatf("vec%0d_miss", i), {31'd0, (cyc > 0)}, {31'd0, tbl[i].miss});
      check($sformatf("vec%0d_writeback", i), {31'd0, wb}, {31'd0, tbl[i].wb});
      check($sformatf("vec%0d_exclusive", i), {31'd0, excl}, 0);
      check($sformatf("vec%0d_readdata", i), {24'd0, rdat}, {24'd0, tbl[i].rdata});
      if (tbl[i].wb) begin
        check($sformatf("vec%0d_wb_address", i), {26'd0, wba}, {26'd0, tbl[i].wba});
        check($sformatf("vec%0d_wb_data", i), wbd, tbl[i].wbd);
      end
    end

    // Reset asserted in the middle of a memory read aborts it.
    apply_reset();
    mem_lat = 3;
    READ = 1'b1; ADDRESS = 8'h25;
    n = 0;
    while (!mem_read && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    check("abort_memrd_started", {31'd0, mem_read}, 1);
    @(posedge CLK); #1;
    RESET = 1'b0;
    #1;
    check("abort_mem_read", {31'd0, mem_read}, 0);
    check("abort_busywait", {31'd0, BUSYWAIT}, 0);
    check("abort_mem_address", {26'd0, mem_address}, 0);
    #1 RESET = 1'b1;
    #1;
    check("abort_remiss_busy", {31'd0, BUSYWAIT}, 1);
    @(posedge CLK); #1;
    check("abort_remiss_memrd", {31'd0, mem_read}, 1);
    check("abort_remiss_address", {26'd0, mem_address}, 32'h09);
    n = 0;
    while (BUSYWAIT && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    w = mem_view(6'h09);
    check("abort_refill_busy", {31'd0, BUSYWAIT}, 0);
    check("abort_refill_readdata", {24'd0, READDATA}, {24'd0, w[15:8]});
    READ = 1'b0;

    // A write miss whose request drops mid-fill still completes the fill, without the write.
    mem_lat = 2;
    WRITE = 1'b1; ADDRESS = 8'h90; WRITEDATA = 8'hEE;
    @(posedge CLK); #1;
    WRITE = 1'b0;
    n = 0;
    while (BUSYWAIT && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    check("drop_fill_finished", {31'd0, BUSYWAIT}, 0);
    do_op(1'b1, 1'b0, 8'h90, 8'h00, cyc, wb, wba, wbd, rdat, excl, tmo);
    w = mem_view(6'h24);
    check("drop_refetch_hit", cyc, 0);
    check("drop_readdata", {24'd0, rdat}, {24'd0, w[7:0]});

    // Randomized traffic against the architectural byte model.
    apply_reset();
    for (int a = 0; a < 256; a++) begin
      w = mem_view(6'(a >> 2));
      ref_bytes[a] = w[(a % 4) * 8 +: 8];
    end
    for (int s = 0; s < 8; s++) begin
      rv[s] = 1'b0; rdirty[s] = 1'b0; rt[s] = 3'd0;
    end
    for (int k = 0; k < 300; k++) begin
      int r, blk, set;
      logic rd, wr, exp_miss, exp_wb;
      logic [2:0] t;
      logic [7:0] a, d;
      logic [5:0] exp_wba;
      logic [31:0] exp_wbd;
      r = $urandom_range(0, 10);
      rd = (r <= 4) || (r == 9);
      wr = (r >= 5 && r <= 9);
      a = 8'($urandom_range(0, 255));
      d = 8'($urandom_range(0, 255));
      mem_lat = $urandom_range(0, 3);
      blk = int'(a) / 4;
      set = blk % 8;
      t = 3'(blk / 8);
      exp_miss = (rd || wr) && !(rv[set] && rt[set] == t);
      exp_wb = exp_miss && rv[set] && rdirty[set];
      exp_wba = {rt[set], 3'(set)};
      for (int b = 0; b < 4; b++)
        exp_wbd[b * 8 +: 8] = ref_bytes[int'(exp_wba) * 4 + b];
      exp_rd = (rd && !wr) ? ref_bytes[a] : 8'h00;
      if (rd || wr) begin
        if (exp_miss) rdirty[set] = 1'b0;
        rv[set] = 1'b1;
        rt[set] = t;
        if (wr) begin
          ref_bytes[a] = d;
          rdirty[set] = 1'b1;
        end
      end
      do_op(rd, wr, a, d, cyc, wb, wba, wbd, rdat, excl, tmo);
      check($sformatf("rnd%0d_timeout", k), {31'd0, tmo}, 0);
      check($sformatf("rnd%0d_miss", k), {31'd0, (cyc > 0)}, {31'd0, exp_miss});
      check($sformatf("rnd%0d_writeback", k), {31'd0, wb}, {31'd0, exp_wb});
      check($sformatf("rnd%0d_exclusive", k), {31'd0, excl}, 0);
      check($sformatf("rnd%0d_readdata", k), {24'd0, rdat}, {24'd0, exp_rd});
      if (exp_wb) begin
        check($sformatf("rnd%0d_wb_address", k), {26'd0, wba}, {26'd0, exp_wba});
        check($sformatf("rnd%0d_wb_data", k), wbd, exp_wbd);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
